// File: rtl/awaddr_axi_issuer_if.sv
// awaddr_axi_issuer_if: AXI4 write-address (AW) and write-response (B)
// channel bundle between the address issuer and the DDR controller.
//   m_awaddr/m_awlen/m_awvalid : AW request, driven by the issuer
//   m_awready                  : AW accept, driven by the controller
//   m_bvalid/m_bresp           : B response, driven by the controller
//   m_bready                   : B accept, driven by the issuer
// Modports: master = issuer side, slave = controller side.
interface awaddr_axi_issuer_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] m_awaddr;
  logic [7:0]            m_awlen;
  logic                  m_awvalid;
  logic                  m_awready;
  logic                  m_bvalid;
  logic [1:0]            m_bresp;
  logic                  m_bready;

  modport master (
    output m_awaddr, m_awlen, m_awvalid, m_bready,
    input  m_awready, m_bvalid, m_bresp
  );

  modport slave (
    input  m_awaddr, m_awlen, m_awvalid, m_bready,
    output m_awready, m_bvalid, m_bresp
  );
endinterface

// File: rtl/awaddr_axi_issuer.sv
// awaddr_axi_issuer: pops burst start addresses from the write-address
// prefetch FIFO and issues them as AXI4 AW bursts, bounding the number of
// bursts in flight by counting B responses. Each accepted AW also emits a
// length command for the W-channel data mover.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   fifo_rd_vld/_data     FWFT FIFO head (burst start byte address)
//   fifo_rd_en            registered pop strobe, one cycle per entry
//   m_axi                 AW/B channels (awaddr_axi_issuer_if.master)
//   wcmd_valid/wcmd_len   one pulse per accepted AW with its awlen
//   busy                  FSM not idle or bursts still outstanding
//   bresp_err             sticky: a B response other than OKAY was seen
//
// Build option: define AWADDR_ISSUER_4K_SPLIT_EN to split any burst that
// would cross a 4 KB boundary into two AWs from a single FIFO pop.
module awaddr_axi_issuer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BEAT_BYTES = 32,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned MAX_OUTST  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_rd_vld,
  input  logic [ADDR_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  awaddr_axi_issuer_if.master   m_axi,
  output logic                  wcmd_valid,
  output logic [7:0]            wcmd_len,
  output logic                  busy,
  output logic                  bresp_err
);

  localparam logic [7:0]            LEN_FULL  = 8'(BURST_LEN - 1);
  localparam logic [7:0]            MAX_CNT   = 8'(MAX_OUTST);
  localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ADDR_WIDTH'(BEAT_BYTES - 1);

`ifdef AWADDR_ISSUER_4K_SPLIT_EN
  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam logic [31:0] FULL_BYTES = 32'(BURST_LEN * BEAT_BYTES);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SPLIT} state_t;
`else
  typedef enum logic {S_IDLE, S_ISSUE} state_t;
`endif

  state_t                r_state, w_state_nxt;
  logic                  r_fifo_rd_en;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]            r_awlen;
  logic                  r_awvalid;
  logic                  r_bready;
  logic [7:0]            r_outst;
  logic                  r_bresp_err;

  logic                  w_room, w_aw_hs, w_b_hs, w_dec;
  logic                  w_req, w_capture, w_load_split;
  logic [ADDR_WIDTH-1:0] w_cap_addr;
  logic [7:0]            w_first_len;

  assign w_room     = (r_outst < MAX_CNT);
  assign w_aw_hs    = r_awvalid & m_axi.m_awready;
  assign w_b_hs     = m_axi.m_bvalid & r_bready;
  // A response with nothing outstanding is ignored so the count cannot wrap.
  assign w_dec      = w_b_hs && (r_outst != '0);
  assign w_cap_addr = fifo_rd_data & ~BEAT_MASK;

`ifdef AWADDR_ISSUER_4K_SPLIT_EN
  logic [31:0]           w_off, w_first_beats;
  logic                  w_cross;
  logic                  r_rem_pend;
  logic [ADDR_WIDTH-1:0] r_rem_addr;
  logic [7:0]            r_rem_len;

  assign w_off         = {20'd0, w_cap_addr[11:0]};
  assign w_cross       = (w_off + FULL_BYTES) > 32'd4096;
  assign w_first_beats = (32'd4096 - w_off) >> BEAT_SHIFT;
  assign w_first_len   = w_cross ? 8'(w_first_beats - 32'd1) : LEN_FULL;
`else
  assign w_first_len   = LEN_FULL;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // The pop is requested one cycle ahead so fifo_rd_en is a flop; the FSM
  // stays in IDLE during the pop cycle and captures the head entry there.
  always_comb begin
    w_state_nxt  = r_state;
    w_req        = 1'b0;
    w_capture    = 1'b0;
    w_load_split = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_fifo_rd_en) begin
          w_capture   = 1'b1;
          w_state_nxt = S_ISSUE;
        end else if (fifo_rd_vld && w_room) begin
          w_req = 1'b1;
        end
      end
      S_ISSUE: begin
        if (w_aw_hs) begin
`ifdef AWADDR_ISSUER_4K_SPLIT_EN
          w_state_nxt = r_rem_pend ? S_SPLIT : S_IDLE;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
`ifdef AWADDR_ISSUER_4K_SPLIT_EN
      S_SPLIT: begin
        if (w_room) begin
          w_load_split = 1'b1;
          w_state_nxt  = S_ISSUE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_rd_en <= 1'b0;
      r_awaddr     <= '0;
      r_awlen      <= '0;
      r_awvalid    <= 1'b0;
      r_bready     <= 1'b0;
      r_outst      <= '0;
      r_bresp_err  <= 1'b0;
`ifdef AWADDR_ISSUER_4K_SPLIT_EN
      r_rem_pend   <= 1'b0;
      r_rem_addr   <= '0;
      r_rem_len    <= '0;
`endif
    end else begin
      r_bready     <= 1'b1;
      r_fifo_rd_en <= w_req;

      if (w_capture) begin
        r_awaddr  <= w_cap_addr;
        r_awlen   <= w_first_len;
        r_awvalid <= 1'b1;
`ifdef AWADDR_ISSUER_4K_SPLIT_EN
        r_rem_pend <= w_cross;
        r_rem_addr <= {w_cap_addr[ADDR_WIDTH-1:12], 12'h000} + ADDR_WIDTH'(4096);
        r_rem_len  <= 8'(32'(BURST_LEN) - w_first_beats - 32'd1);
      end else if (w_load_split) begin
        r_awaddr   <= r_rem_addr;
        r_awlen    <= r_rem_len;
        r_awvalid  <= 1'b1;
        r_rem_pend <= 1'b0;
`endif
      end else if (w_aw_hs) begin
        r_awvalid <= 1'b0;
      end

      case ({w_aw_hs, w_dec})
        2'b10:   r_outst <= r_outst + 8'd1;
        2'b01:   r_outst <= r_outst - 8'd1;
        default: r_outst <= r_outst;
      endcase

      if (w_b_hs && (m_axi.m_bresp != 2'b00)) r_bresp_err <= 1'b1;
    end
  end

  assign fifo_rd_en      = r_fifo_rd_en;
  assign m_axi.m_awaddr  = r_awaddr;
  assign m_axi.m_awlen   = r_awlen;
  assign m_axi.m_awvalid = r_awvalid;
  assign m_axi.m_bready  = r_bready;
  assign wcmd_valid      = w_aw_hs;
  assign wcmd_len        = r_awlen;
  assign busy            = (r_state != S_IDLE) || (r_outst != '0);
  assign bresp_err       = r_bresp_err;

endmodule

// File: doc/awaddr_axi_issuer.md
Name: awaddr_axi_issuer

Overview:
- Downstream consumer of the DDR write-address prefetch FIFO.
- Pops one burst start address per entry and issues it on the AXI4 write-address (AW) channel of the DDR controller.
- Limits outstanding write bursts using B-channel responses.
- Emits a per-burst length command to the W-channel data mover.

Parameters:
ADDR_WIDTH, 32, byte address width; matches the FIFO data width.
BEAT_BYTES, 32, bytes per AXI data beat (power of 2).
BURST_LEN, 16, beats per FIFO entry (1..256).
MAX_OUTST, 8, max AW bursts issued without a B response (1..255).

Ports:
clk  in  1  single clock for all logic.
rst_n  in  1  asynchronous assert, active-low reset.
fifo_rd_vld  in  1  FIFO head entry valid (prefetch/FWFT).
fifo_rd_data  in  ADDR_WIDTH  FIFO head entry: burst start byte address.
fifo_rd_en  out  1  pop strobe, one cycle per entry.
m_awaddr  out  ADDR_WIDTH  AXI AW address.
m_awlen  out  8  AXI AW length (beats-1).
m_awvalid  out  1  AXI AW valid.
m_awready  in  1  AXI AW ready.
m_bvalid  in  1  AXI B valid.
m_bresp  in  2  AXI B response.
m_bready  out  1  AXI B ready.
wcmd_valid  out  1  one-cycle pulse per accepted AW.
wcmd_len  out  8  beat count minus 1 of that AW.
busy  out  1  high when FSM is not IDLE or outstanding count is nonzero.
bresp_err  out  1  sticky flag, set on any non-OKAY response.

Behaviour:
- Reset values: all outputs 0 except m_bready, which is 1 one cycle after reset release. FSM resets to IDLE; outstanding count resets to 0.
- Burst sizing:
  - Address low log2(BEAT_BYTES) bits are forced to 0 on capture.
  - Full burst = BURST_LEN*BEAT_BYTES bytes.
- FSM IDLE:
  - Condition: fifo_rd_vld=1 and outst_cnt<MAX_OUTST.
  - Action: fifo_rd_en=1 for exactly that cycle; fifo_rd_data is captured the same cycle.
  - Compute first-burst len and any remainder; go to ISSUE.
  - fifo_rd_en is registered; it is never asserted outside IDLE.
- FSM ISSUE:
  - m_awvalid=1 the cycle after the pop (latency 1 from pop to awvalid).
  - m_awaddr/m_awlen are registered and held stable while awvalid=1 and awready=0.
  - On awvalid&awready: outst_cnt+1 and wcmd_valid pulse with wcmd_len=m_awlen.
  - Next state is SPLIT if a remainder is pending, else IDLE.
  - m_awvalid deasserts the cycle after the handshake unless a new AW is ready.
- FSM SPLIT:
  - Waits for outst_cnt<MAX_OUTST.
  - Loads the remainder address/len, then goes to ISSUE.
- Outstanding counter:
  - +1 on AW handshake; -1 on m_bvalid&m_bready.
  - Both in the same cycle leaves it unchanged.
  - Never exceeds MAX_OUTST. A B response with outst_cnt=0 is ignored and does not underflow.
- bresp_err is set on any B handshake with m_bresp!=2'b00 and is cleared only by reset.
- m_awvalid never depends combinationally on m_awready. No AW is issued without a FIFO entry.
- Reset mid-operation:
  - All state clears immediately and the outstanding count is lost.
  - Any captured entry not yet issued is discarded; the FIFO is not rewound.

Optional Feature:
Macro AWADDR_ISSUER_4K_SPLIT_EN.
- Defined:
  - A burst whose span crosses a 4 KB boundary (addr[11:0] + full burst bytes > 4096) is split in two.
  - First AW: len = ((4096 - addr[11:0]) / BEAT_BYTES) - 1.
  - Second AW: address = next 4 KB boundary, len = remaining beats - 1.
  - Both AWs come from a single FIFO pop; each produces a wcmd pulse.
- Undefined:
  - SPLIT state and boundary logic are absent.
  - Every entry issues one AW with len = BURST_LEN-1.

Test Plan:
- fifo_rd_data=0x0000_2000, awready=1 -> pop at T, awvalid at T+1 with addr 0x2000, len 15, wcmd_len 15; busy=1 until the B response arrives.
- Split enabled, addr 0x0000_0F00 -> AW addr 0x0F00 len 7, then AW addr 0x1000 len 7; exactly one pop; two wcmd pulses.
- Split disabled, addr 0x0000_0F00 -> single AW addr 0x0F00 len 15.
- 10 entries queued, no B responses, MAX_OUTST=8 -> exactly 8 AWs and 8 pops, then stall. One B response -> exactly one more AW.
- awready held 0 for 5 cycles during ISSUE -> awvalid, addr, len stable all 5 cycles; no wcmd pulse until the handshake.
- B response with bresp=2'b10 -> bresp_err=1 and stays 1. rst_n pulsed low mid-ISSUE -> all outputs 0, outst_cnt=0, next entry issues normally.
